// File: rtl/sle_pkg.sv
// Shared definitions for the SLE-bank utilities: FSM state encoding and a
// constant-evaluable clog2 for sizing counters and selects.
package sle_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sle_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sle_piso.sv
// Shadow register for the SLE bank snapshot: parallel load on enable,
// single bit selected by index for serialisation.
module sle_piso #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [SEL_W-1:0] sel,
  output logic             q_bit
);

  logic [WIDTH-1:0] shadow_q;

  always_ff @(posedge clk) begin
    if (load) shadow_q <= d;
  end

  // Indices past the top cell read as 0 when WIDTH is not a power of two.
  always_comb begin
    q_bit = 1'b0;
    if (int'(sel) < WIDTH) q_bit = shadow_q[sel];
  end

endmodule

// File: rtl/sle_readback.sv
// Serial readback engine: snapshots the SLE bank Q outputs and streams them
// LSB first over valid/ready, optionally followed by an even-parity bit.
module sle_readback
  import sle_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int PARITY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_req,
  input  logic [WIDTH-1:0] cap_data,
  output logic             busy,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             done,
  output logic             ovr
);

  localparam int N     = WIDTH + PARITY;
  localparam int CNT_W = clog2(N);
  localparam int SEL_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] PAR_IDX  = CNT_W'(WIDTH);

  sle_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             par_bit;
  logic             data_bit;
  logic             load;
  logic             is_par;
  logic             hs;

  assign load = (state == IDLE) && cap_req;

  sle_piso #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_piso (
    .clk   (clk),
    .load  (load),
    .d     (cap_data),
    .sel   (cnt[SEL_W-1:0]),
    .q_bit (data_bit)
  );

  // Parity is taken from the same snapshot as the shadow word.
  always_ff @(posedge clk) begin
    if (load) par_bit <= ^cap_data;
  end

  // PARITY guards the compare: with PARITY=0 PAR_IDX can alias a data index.
  assign is_par     = (PARITY != 0) && (cnt == PAR_IDX);
  assign sout_valid = (state == SHIFT);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign sout_last  = sout_valid && (cnt == LAST_IDX);
  assign sout       = sout_valid && (is_par ? par_bit : data_bit);
  assign hs         = sout_valid && sout_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ovr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cap_req) begin
            state <= SHIFT;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (cap_req) ovr <= 1'b1;
          if (hs) begin
            if (cnt == LAST_IDX) state <= DONE;
            else                 cnt   <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (cap_req) ovr <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
